// File: rtl/i2s_stereo_receiver.sv
// i2s_stereo_receiver: I2S master receiver generating SCK/WS, capturing left/right
// slots per run-time mode and buffering channel-tagged samples in a FWFT FIFO.
module i2s_stereo_receiver #(
  parameter int DATA_SIZE    = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int I2S_CLK_FREQ = 3_072_000,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic                         clear_overrun,
  input  logic                         i2s_sd,
  output logic                         i2s_sck,
  output logic                         i2s_ws,
  output logic [DATA_SIZE-1:0]         sample_data,
  output logic                         sample_ch,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overrun
);
  localparam int DIV_HALF = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam int DW = $clog2(DIV_HALF);
  localparam int SB = $clog2(SLOT_WIDTH);
  localparam int PW = SB + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  if (DIV_HALF < 2) begin : g_div_check
    $error("i2s_stereo_receiver: DIV_HALF must be at least 2");
  end

  logic [DW-1:0]        div;
  logic [PW-1:0]        pos;
  logic [PW-1:0]        pos_nxt;
  logic [SB-1:0]        bit_idx;
  logic [DATA_SIZE-1:0] shift;
  logic [DATA_SIZE-1:0] pend_data;
  logic [1:0]           act_mode;
  logic                 en_d, pend_valid, pend_ch;
  logic                 toggle, rise, fall, wrap, last_bit, ch_en;

  assign toggle   = div == DW'(DIV_HALF - 1);
  assign rise     = toggle && !i2s_sck;
  assign fall     = toggle && i2s_sck;
  assign wrap     = pos == PW'(2 * SLOT_WIDTH - 1);
  assign pos_nxt  = wrap ? '0 : pos + 1'b1;
  assign bit_idx  = pos[SB-1:0];
  assign last_bit = rise && bit_idx == SB'(DATA_SIZE);
  assign ch_en    = act_mode == 2'b00 ? !pos[SB] : act_mode == 2'b01 ? pos[SB] : 1'b1;

  // Bit 0 of each slot is the I2S delay bit; bits past DATA_SIZE are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      pos        <= '0;
      shift      <= '0;
      i2s_sck    <= 1'b0;
      i2s_ws     <= 1'b0;
      act_mode   <= 2'b00;
      en_d       <= 1'b0;
      pend_valid <= 1'b0;
      pend_ch    <= 1'b0;
      pend_data  <= '0;
    end else begin
      en_d       <= enable;
      pend_valid <= enable && last_bit && ch_en;
      if (last_bit) begin
        pend_ch   <= pos[SB];
        pend_data <= {shift[DATA_SIZE-2:0], i2s_sd};
      end
      if (!enable) begin
        div     <= '0;
        pos     <= '0;
        shift   <= '0;
        i2s_sck <= 1'b0;
        i2s_ws  <= 1'b0;
      end else begin
        if (!en_d) act_mode <= mode;
        div <= toggle ? '0 : div + 1'b1;
        if (toggle) i2s_sck <= !i2s_sck;
        if (fall) begin
          pos    <= pos_nxt;
          i2s_ws <= pos_nxt[SB];
          if (wrap) act_mode <= mode;
        end
        if (rise && bit_idx != '0 && bit_idx <= SB'(DATA_SIZE))
          shift <= {shift[DATA_SIZE-2:0], i2s_sd};
      end
    end
  end

  logic [DATA_SIZE:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      level;
  logic               pop, full, push, drop;

  assign sample_valid = level != '0;
  assign fifo_level   = level;
  assign pop          = sample_valid && sample_ready;
  assign full         = level == LW'(FIFO_DEPTH);
  assign push         = pend_valid && (!full || pop);
  assign drop         = pend_valid && full && !pop;
  assign {sample_ch, sample_data} = sample_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pend_ch, pend_data};
  end

  // A drop in the same cycle as clear_overrun keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr + AW'(pop);
      level   <= level + LW'(push) - LW'(pop);
      overrun <= drop || (overrun && !clear_overrun);
    end
  end
endmodule

// File: doc/i2s_stereo_receiver.md
# i2s_stereo_receiver

Parametrised I2S master receiver: generates SCK and WS, deserialises one or both channels of a standard (Philips, one-bit-delayed) I2S stream, and buffers tagged samples in an internal first-word-fall-through FIFO with a valid/ready output. It sits between an external I2S microphone or ADC and the audio processing pipeline. It generalises the single-channel capture block with configurable slot width, run-time channel mode, an output FIFO and overrun reporting.

## Interface
- DATA_SIZE, 24, sample bits captured per slot, MSB first; 8..SLOT_WIDTH-1
- SLOT_WIDTH, 32, SCK cycles per channel slot; 16 or 32
- CLK_FREQ, 100_000_000, clk frequency in Hz
- I2S_CLK_FREQ, 3_072_000, target SCK frequency in Hz
- FIFO_DEPTH, 8, sample entries; power of 2, >= 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run interface; low stops SCK/WS
- mode  in  2  00 left only, 01 right only, 10 stereo, 11 treated as stereo
- clear_overrun  in  1  clears sticky overrun flag
- i2s_sd  in  1  serial data from device
- i2s_sck  out  1  bit clock
- i2s_ws  out  1  word select: 0 left, 1 right
- sample_data  out  DATA_SIZE  FIFO head sample
- sample_ch  out  1  FIFO head channel tag: 0 left, 1 right
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  consumer accepts head
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored
- overrun  out  1  sticky: a sample was dropped on full FIFO

## Operation
- DIV_HALF = CLK_FREQ / (2*I2S_CLK_FREQ), integer division; elaboration error if DIV_HALF < 2. Defaults give 16 (SCK period 32 clk).
- Divider counts 0..DIV_HALF-1; i2s_sck toggles on the cycle the counter is at DIV_HALF-1, counter wraps to 0.
- Frame position pos counts 0..2*SLOT_WIDTH-1, advanced on every SCK falling toggle; wraps to 0.
- i2s_ws updated together with each falling toggle: 1 when the new pos >= SLOT_WIDTH, else 0.
- Capture on the clk cycle of each SCK rising toggle, slot bit b = pos mod SLOT_WIDTH: b = 0 ignored (I2S delay bit); b = 1..DATA_SIZE shifted in MSB first; b > DATA_SIZE ignored (tristate).
- At b = DATA_SIZE, the completed sample is pushed with tag = pos >= SLOT_WIDTH, if its channel is enabled by the active mode.
- mode sampled into active mode only when pos wraps to 0 and at enable rising; mid-frame changes take effect next frame.
- FIFO: push on completed sample; pop when sample_valid && sample_ready. Simultaneous push and pop on full FIFO: both succeed, level unchanged, no overrun.
- Push on full without pop: sample dropped, FIFO unchanged, overrun set. clear_overrun clears it; a drop in the same cycle as clear_overrun wins (flag stays 1).
- enable low: divider, pos, shift register cleared, i2s_sck and i2s_ws forced 0 next cycle, partial sample discarded; FIFO contents and pop path keep working. enable high: restart at pos 0, divider 0.
- Reset mid-operation: everything returns to reset state immediately; FIFO emptied.

## Timing
- Reset values: i2s_sck 0, i2s_ws 0, sample_valid 0, sample_data 0, sample_ch 0, fifo_level 0, overrun 0.
- After enable rise, first SCK rising toggle after DIV_HALF clk cycles.
- i2s_sd captured as present on the clk edge that registers the SCK rising toggle (no synchroniser).
- Push occurs on the clk cycle after capture of bit DATA_SIZE; sample_valid, sample_data, sample_ch, fifo_level update on the following clk edge (2 cycles from last-bit capture to visible at head, FIFO empty).
- Pop: head advances and fifo_level decrements on the edge where sample_valid && sample_ready; new head is visible after that edge.
- sample_data/sample_ch stable while sample_valid && !sample_ready.
- Stereo: at most 2 pushes per frame, separated by SLOT_WIDTH SCK periods.

## Test plan
- Defaults, stereo, ready held 1, device model sends left 0xA5A5A5, right 0x5A5A5A -> sample (ch 0, 0xA5A5A5) then (ch 1, 0x5A5A5A) per frame; SCK period 32 clk, WS period 2048 clk, WS edges coincide with SCK falls.
- mode 01, left 0x123456, right 0x654321 -> only (ch 1, 0x654321) each frame; switch to 00 mid-frame -> change takes effect from next frame only.
- ready held 0, stereo, 5 frames -> fifo_level saturates at 8, overrun 1 after 9th sample, head remains first sample; clear_overrun pulse -> overrun 0; pop all -> 8 oldest samples in order.
- Full FIFO, ready 1 exactly on a push cycle -> level stays 8, overrun stays 0.
- enable dropped mid-left-slot then restored -> no partial sample pushed; SCK/WS 0 while disabled; capture resumes correctly from pos 0.
- SLOT_WIDTH 16, DATA_SIZE 12, stereo, left 0xABC, right 0x321 -> samples 0xABC/0x321; rst_n asserted mid-frame -> all outputs at reset values immediately.
